// File: rtl/pwm_pkg.sv
// Shared types and constants for the PWM scheduler: FSM states, config
// select offsets (relative to the channel count) and register reset values.
package pwm_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_WAIT = 2'd2
   } pwm_state_t;

   // cfg_sel codes above the duty range are NCH + offset
   localparam int SEL_PERIOD = 0;
   localparam int SEL_PRESC  = 1;
   localparam int SEL_MASK   = 2;
   localparam int SEL_COMMIT = 3;

   // Period resets to all ones; this bit is replicated to the counter width
   localparam logic DEF_PERIOD_BIT = 1'b1;
   localparam int   DEF_DUTY       = 0;
   localparam int   DEF_PRESC      = 0;
   localparam int   DEF_MASK       = 0;

endpackage

// File: rtl/pwm_prescaler.sv
// Single-clock prescaler: counts 0..presc and pulses tick at presc, then wraps.
// clear holds/restarts the count at 0 (idle hold and commit restart).
module pwm_prescaler
   import pwm_pkg::*;
#(
   parameter int PSW = 8
) (
   input  logic           clk_in,
   input  logic           rst,
   input  logic           clear,
   input  logic [PSW-1:0] presc,
   output logic           tick
);

   logic [PSW-1:0] cnt_q;
   logic [PSW-1:0] cnt_d;

   assign tick = (cnt_q == presc);

   always_comb begin
      cnt_d = cnt_q + PSW'(1);
      if (clear || tick) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/pwm_sched.sv
// PWM channel scheduler: shadow/active register sets, commit sequencing FSM,
// shared period counter and per-channel duty compare with registered outputs.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | active mask is zero; prescaler and counter held at 0
//   RUN     | counting periods; config writes only touch shadow registers
//   WAIT    | commit accepted; shadow applied at the next period boundary
module pwm_sched
   import pwm_pkg::*;
#(
   parameter int NCH = 4,
   parameter int CW  = 16,
   parameter int PSW = 8,
   parameter int SW  = $clog2(NCH + 4)
) (
   input  logic           clk_in,
   input  logic           rst,
   input  logic           cfg_valid,
   output logic           cfg_ready,
   input  logic [SW-1:0]  cfg_sel,
   input  logic [CW-1:0]  cfg_data,
   output logic [NCH-1:0] pwm_out,
   output logic           period_start,
   output logic           pending
);

   localparam logic [SW-1:0]  SEL_P      = SW'(NCH + SEL_PERIOD);
   localparam logic [SW-1:0]  SEL_S      = SW'(NCH + SEL_PRESC);
   localparam logic [SW-1:0]  SEL_M      = SW'(NCH + SEL_MASK);
   localparam logic [SW-1:0]  SEL_C      = SW'(NCH + SEL_COMMIT);
   localparam logic [CW-1:0]  PERIOD_RST = {CW{DEF_PERIOD_BIT}};
   localparam logic [CW-1:0]  DUTY_RST   = CW'(DEF_DUTY);
   localparam logic [PSW-1:0] PRESC_RST  = PSW'(DEF_PRESC);
   localparam logic [NCH-1:0] MASK_RST   = NCH'(DEF_MASK);

   pwm_state_t     state_q, state_d;

   logic [CW-1:0]  sh_period_q, sh_period_d;
   logic [PSW-1:0] sh_presc_q,  sh_presc_d;
   logic [NCH-1:0] sh_mask_q,   sh_mask_d;
   logic [CW-1:0]  sh_duty_q [NCH];
   logic [CW-1:0]  sh_duty_d [NCH];

   logic [CW-1:0]  act_period_q, act_period_d;
   logic [PSW-1:0] act_presc_q,  act_presc_d;
   logic [NCH-1:0] act_mask_q,   act_mask_d;
   logic [CW-1:0]  act_duty_q [NCH];
   logic [CW-1:0]  act_duty_d [NCH];

   logic           apply_q, apply_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic           period_start_q, period_start_d;
   logic [NCH-1:0] pwm_q, pwm_d;

   logic cfg_acc;
   logic commit_acc;
   logic running;
   logic tick_raw;
   logic tick;
   logic wrap;
   logic idle_apply;
   logic wait_apply;
   logic load_act;
   logic new_run;
   logic presc_clear;

   assign cfg_acc    = cfg_valid && cfg_ready;
   assign commit_acc = cfg_acc && (cfg_sel == SEL_C);
   assign running    = (state_q != ST_IDLE);
   assign tick       = tick_raw && running;
   assign wrap       = tick && (cnt_q == act_period_q);
   // A commit landing on the apply cycle restarts the one-cycle delay
   assign idle_apply = (state_q == ST_IDLE) && apply_q && !commit_acc;
   assign wait_apply = (state_q == ST_WAIT) && wrap;
   assign load_act   = idle_apply || wait_apply;
   assign new_run    = (sh_mask_q != '0);
   assign presc_clear = !running || load_act;

   pwm_prescaler #(
      .PSW (PSW)
   ) u_prescaler (
      .clk_in (clk_in),
      .rst    (rst),
      .clear  (presc_clear),
      .presc  (act_presc_q),
      .tick   (tick_raw)
   );

   // FSM: state register
   always_ff @(posedge clk_in) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM: next state
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: if (idle_apply && new_run) state_d = ST_RUN;
         ST_RUN:  if (commit_acc)            state_d = ST_WAIT;
         ST_WAIT: if (wait_apply)            state_d = new_run ? ST_RUN : ST_IDLE;
         default:                            state_d = ST_IDLE;
      endcase
   end

   // FSM: outputs
   always_comb begin
      cfg_ready = (state_q != ST_WAIT);
      pending   = (state_q == ST_WAIT);
   end

   always_comb begin
      sh_period_d = sh_period_q;
      sh_presc_d  = sh_presc_q;
      sh_mask_d   = sh_mask_q;
      for (int i = 0; i < NCH; i++) begin
         sh_duty_d[i] = (cfg_acc && (cfg_sel == SW'(i))) ? cfg_data : sh_duty_q[i];
      end
      if (cfg_acc && (cfg_sel == SEL_P)) sh_period_d = cfg_data;
      if (cfg_acc && (cfg_sel == SEL_S)) sh_presc_d  = cfg_data[PSW-1:0];
      if (cfg_acc && (cfg_sel == SEL_M)) sh_mask_d   = cfg_data[NCH-1:0];
   end

   always_comb begin
      act_period_d = load_act ? sh_period_q : act_period_q;
      act_presc_d  = load_act ? sh_presc_q  : act_presc_q;
      act_mask_d   = load_act ? sh_mask_q   : act_mask_q;
      for (int i = 0; i < NCH; i++) begin
         act_duty_d[i] = load_act ? sh_duty_q[i] : act_duty_q[i];
      end
   end

   always_comb begin
      apply_d = 1'b0;
      if (state_q == ST_IDLE) begin
         apply_d = commit_acc || (apply_q && !idle_apply);
      end
   end

   always_comb begin
      cnt_d = cnt_q;
      if (!running || wrap) begin
         cnt_d = '0;
      end else if (tick) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   // Pulse marks the first cnt==0 cycle of each period in RUN
   assign period_start_d = (idle_apply && new_run) ||
                           (wrap && ((state_q == ST_RUN) || new_run));

   for (genvar g = 0; g < NCH; g++) begin : g_ch
      assign pwm_d[g] = running && act_mask_q[g] && (cnt_q < act_duty_q[g]);
   end

   always_ff @(posedge clk_in) begin
      if (rst) begin
         sh_period_q    <= PERIOD_RST;
         sh_presc_q     <= PRESC_RST;
         sh_mask_q      <= MASK_RST;
         act_period_q   <= PERIOD_RST;
         act_presc_q    <= PRESC_RST;
         act_mask_q     <= MASK_RST;
         apply_q        <= 1'b0;
         cnt_q          <= '0;
         period_start_q <= 1'b0;
         pwm_q          <= '0;
         for (int i = 0; i < NCH; i++) begin
            sh_duty_q[i]  <= DUTY_RST;
            act_duty_q[i] <= DUTY_RST;
         end
      end else begin
         sh_period_q    <= sh_period_d;
         sh_presc_q     <= sh_presc_d;
         sh_mask_q      <= sh_mask_d;
         act_period_q   <= act_period_d;
         act_presc_q    <= act_presc_d;
         act_mask_q     <= act_mask_d;
         apply_q        <= apply_d;
         cnt_q          <= cnt_d;
         period_start_q <= period_start_d;
         pwm_q          <= pwm_d;
         for (int i = 0; i < NCH; i++) begin
            sh_duty_q[i]  <= sh_duty_d[i];
            act_duty_q[i] <= act_duty_d[i];
         end
      end
   end

   assign pwm_out      = pwm_q;
   assign period_start = period_start_q;

endmodule
